// File: rtl/noc_pkg.sv
// Shared flit-format constants and arbiter state encoding for the NoC port arbiter.
package noc_pkg;

  localparam int unsigned FLIT_W = 16;

  // Flit type codes carried in the top two bits of every flit
  localparam logic [1:0] FLIT_HEAD   = 2'b00;
  localparam logic [1:0] FLIT_BODY   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  // Field positions inside a flit (src/des/data are meaningful on heads only)
  localparam int unsigned TYPE_MSB = 15;
  localparam int unsigned TYPE_LSB = 14;
  localparam int unsigned SRC_MSB  = 13;
  localparam int unsigned SRC_LSB  = 10;
  localparam int unsigned DES_MSB  = 9;
  localparam int unsigned DES_LSB  = 6;
  localparam int unsigned DATA_MSB = 5;
  localparam int unsigned DATA_LSB = 0;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
    return flit[TYPE_MSB:TYPE_LSB];
  endfunction

  // HEAD and SINGLE both open a packet
  function automatic logic is_head(input logic [1:0] ftype);
    return (ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/noc_port_arbiter_if.sv
// Requester-side and link-side handshake bundle of the NoC port arbiter.
interface noc_port_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned FLIT_W = 16
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*FLIT_W-1:0] req_flit;
  logic [NREQ-1:0]        req_ready;
  logic                   out_valid;
  logic [FLIT_W-1:0]      out_flit;
  logic                   out_ready;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   err;

  // master: flit sources plus downstream sink; slave: the arbiter itself
  modport master (
    output req_valid, req_flit, out_ready,
    input  req_ready, out_valid, out_flit, grant, busy, err
  );

  modport slave (
    input  req_valid, req_flit, out_ready,
    output req_ready, out_valid, out_flit, grant, busy, err
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_picker #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic             found_o
);

  // Walk the requesters starting at the pointer and keep the first hit
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant_o = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PTR_W'((32'(ptr_i) + k) % NREQ);
      if (!found_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Wormhole round-robin arbiter: one registered 16-bit output link shared by NREQ sources.
// A packet owns the link from its HEAD until its TAIL (or a leading SINGLE) is accepted.
// Optional build macro ARB_TIMEOUT_EN adds an idle-owner timeout that drops the lock.
module noc_port_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned FLIT_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst,
  noc_port_arbiter_if.slave  bus_io
);

  import noc_pkg::*;

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_q, state_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              first_q, first_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              err_q, err_d;
  logic [NREQ-1:0]   orphan_q, orphan_d;

  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   win_onehot;
  logic              win_found;
  logic [PtrW-1:0]   win_idx;
  logic [FLIT_W-1:0] own_flit;
  logic [1:0]        own_type;
  logic              space;
  logic              accept;
  logic              rel_lock;
  logic [PtrW-1:0]   next_ptr;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] TmoLast = 4'(TIMEOUT - 1);
  logic [3:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign space    = !out_valid_q || bus_io.out_ready;
  assign own_flit = bus_io.req_flit[owner_q*FLIT_W +: FLIT_W];
  assign own_type = flit_type(own_flit);
  assign next_ptr = (owner_q == PtrW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // Classify each requester's flit: packet openers compete, strays in IDLE are orphans
  always_comb begin
    eligible = '0;
    orphan_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = bus_io.req_valid[i] && is_head(flit_type(bus_io.req_flit[i*FLIT_W +: FLIT_W]));
      orphan_d[i] = (state_q == ARB_IDLE) && bus_io.req_valid[i] && !eligible[i];
    end
  end

  rr_picker #(
    .NREQ  (NREQ),
    .PTR_W (PtrW)
  ) u_picker (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .grant_o (win_onehot),
    .found_o (win_found)
  );

  // One-hot winner to index
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_onehot[i]) win_idx = PtrW'(i);
    end
  end

  // Next-state, output-stage and error logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    first_d     = first_q;
    out_valid_d = out_valid_q && !bus_io.out_ready;
    out_flit_d  = out_flit_q;
    // err only on the first cycle a stray flit shows up
    err_d       = |(orphan_d & ~orphan_q);
    req_ready   = '0;
    accept      = 1'b0;
    rel_lock    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        // Arbitration cycle: grant only, nothing is accepted yet
        if (win_found) begin
          state_d = ARB_LOCKED;
          owner_d = win_idx;
          first_d = 1'b1;
        end
      end
      ARB_LOCKED: begin
        req_ready[owner_q] = space;
        accept             = bus_io.req_valid[owner_q] && space;
        if (accept) begin
          out_flit_d  = own_flit;
          out_valid_d = 1'b1;
          first_d     = 1'b0;
          if ((own_type == FLIT_TAIL) || ((own_type == FLIT_SINGLE) && first_q)) begin
            rel_lock = 1'b1;
          end else if (is_head(own_type) && !first_q) begin
            // Opener inside a packet: forward it but flag the protocol breach
            err_d = 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        if (accept) begin
          tmo_cnt_d = '0;
        end else if (!bus_io.req_valid[owner_q]) begin
          if (tmo_cnt_q == TmoLast) begin
            rel_lock  = 1'b1;
            err_d     = 1'b1;
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 4'd1;
          end
        end
`endif
        if (rel_lock) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Current owner as one-hot; empty when idle
  always_comb begin
    grant = '0;
    if (state_q == ARB_LOCKED) grant[owner_q] = 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      err_q       <= 1'b0;
      orphan_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      err_q       <= err_d;
      orphan_q    <= orphan_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Idle-owner counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign bus_io.req_ready = req_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_flit  = out_flit_q;
  assign bus_io.grant     = grant;
  assign bus_io.busy      = (state_q == ARB_LOCKED);
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Bench for noc_port_arbiter: cycle table, hand sequences and a randomized packet scoreboard.
module tb_noc_port_arbiter;
  import noc_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned FW   = 16;
  localparam int unsigned TMO  = 15;
  localparam int          NVEC = 20;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  noc_port_arbiter_if #(.NREQ(NREQ), .FLIT_W(FW)) bus ();

  noc_port_arbiter #(
    .NREQ    (NREQ),
    .FLIT_W  (FW),
    .TIMEOUT (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NREQ-1:0]    rv;
    logic [NREQ*FW-1:0] fl;
    logic [NREQ-1:0]    e_rdy;
    logic               e_ov;
    logic [FW-1:0]      e_flit;
    logic [NREQ-1:0]    e_gnt;
    logic               e_busy;
    logic               e_err;
  } vec_t;

  vec_t vt [NVEC];

  typedef logic [FW-1:0] fq_t[$];
  fq_t           rq [NREQ];
  logic [FW-1:0] exp_q[$];
  int            gap [NREQ];
  bit            use_gaps;
  logic          prev_stall;
  logic [FW-1:0] prev_flit;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic vec_t mk(input logic [NREQ-1:0] rv, input logic [FW-1:0] f0,
                              input logic [FW-1:0] f1, input logic [FW-1:0] f2,
                              input logic [FW-1:0] f3, input logic [NREQ-1:0] rdy,
                              input logic ov, input logic [FW-1:0] of,
                              input logic [NREQ-1:0] g, input logic b, input logic e);
    vec_t v;
    v.rv     = rv;
    v.fl     = {f3, f2, f1, f0};
    v.e_rdy  = rdy;
    v.e_ov   = ov;
    v.e_flit = of;
    v.e_gnt  = g;
    v.e_busy = b;
    v.e_err  = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_flit  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rq[i].delete();
      gap[i] = 0;
    end
    exp_q.delete();
    prev_stall = 1'b0;
    prev_flit  = '0;
    tick();
    rst = 1'b0;
  endtask

  // Queue a packet on requester i; the expected stream is built in service order
  task automatic gen_packet(input int i, input int len);
    logic [FW-1:0] f;
    logic [13:0]   pl;
    for (int k = 0; k < len; k++) begin
      pl = 14'($urandom);
      if (len == 1)          f = {FLIT_SINGLE, pl};
      else if (k == 0)       f = {FLIT_HEAD, pl};
      else if (k == len - 1) f = {FLIT_TAIL, pl};
      else                   f = {FLIT_BODY, pl};
      rq[i].push_back(f);
      exp_q.push_back(f);
    end
  endtask

  // One clock of the queue-driven sources and the downstream sink
  task automatic drive_cycle(input logic ordy);
    logic [NREQ-1:0]    rv;
    logic [NREQ*FW-1:0] fl;
    logic [NREQ-1:0]    acc;
    logic               xfer;
    logic [FW-1:0]      of;
    logic [FW-1:0]      f;
    rv = '0;
    fl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        fl[i*FW +: FW] = rq[i][0];
        rv[i]          = (gap[i] == 0);
      end
    end
    bus.req_valid = rv;
    bus.req_flit  = fl;
    bus.out_ready = ordy;
    #2;
    check("ready_within_grant", bus.req_ready & ~bus.grant, 0);
    check("grant_onehot0", $onehot0(bus.grant), 1);
    if (prev_stall) begin
      check("stall_valid_held", bus.out_valid, 1);
      check("stall_flit_held", bus.out_flit, prev_flit);
    end
    if (bus.out_valid && !ordy) check("stall_no_ready", bus.req_ready, 0);
    check("no_err", bus.err, 0);
    acc        = rv & bus.req_ready;
    xfer       = bus.out_valid && ordy;
    of         = bus.out_flit;
    prev_stall = bus.out_valid && !ordy;
    prev_flit  = of;
    tick();
    if (xfer) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_flit: got=%0h want=none at %0t", of, $time);
      end else begin
        check("out_flit_order", of, exp_q.pop_front());
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        f = rq[i].pop_front();
        if (use_gaps && (f[15:14] == FLIT_HEAD || f[15:14] == FLIT_BODY))
          gap[i] = $urandom_range(0, 2);
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
  endtask

  task automatic run_drain(input int budget, input int ready_pct);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      drive_cycle($urandom_range(0, 99) < ready_pct);
      c++;
    end
    check("drained", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    vt[0]  = mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0);
    vt[1]  = mk(4'b0100, 16'h0, 16'h0, 16'h0A45, 16'h0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0);
    vt[2]  = mk(4'b0100, 16'h0, 16'h0, 16'h0A45, 16'h0, 4'b0100, 0, 16'h0000, 4'b0100, 1, 0);
    vt[3]  = mk(4'b0100, 16'h0, 16'h0, 16'h5123, 16'h0, 4'b0100, 1, 16'h0A45, 4'b0100, 1, 0);
    vt[4]  = mk(4'b0100, 16'h0, 16'h0, 16'h8FFF, 16'h0, 4'b0100, 1, 16'h5123, 4'b0100, 1, 0);
    vt[5]  = mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 1, 16'h8FFF, 4'b0000, 0, 0);
    vt[6]  = mk(4'b0010, 16'h0, 16'hC123, 16'h0, 16'h0, 4'b0000, 0, 16'h8FFF, 4'b0000, 0, 0);
    vt[7]  = mk(4'b0011, 16'h0123, 16'hC123, 16'h0, 16'h0, 4'b0010, 0, 16'h8FFF, 4'b0010, 1, 0);
    vt[8]  = mk(4'b0001, 16'h0123, 16'h0, 16'h0, 16'h0, 4'b0000, 1, 16'hC123, 4'b0000, 0, 0);
    vt[9]  = mk(4'b0001, 16'h0123, 16'h0, 16'h0, 16'h0, 4'b0001, 0, 16'hC123, 4'b0001, 1, 0);
    vt[10] = mk(4'b0001, 16'h8002, 16'h0, 16'h0, 16'h0, 4'b0001, 1, 16'h0123, 4'b0001, 1, 0);
    vt[11] = mk(4'b1000, 16'h0, 16'h0, 16'h0, 16'h4001, 4'b0000, 1, 16'h8002, 4'b0000, 0, 0);
    vt[12] = mk(4'b1000, 16'h0, 16'h0, 16'h0, 16'h4001, 4'b0000, 0, 16'h8002, 4'b0000, 0, 1);
    vt[13] = mk(4'b1000, 16'h0, 16'h0, 16'h0, 16'h4001, 4'b0000, 0, 16'h8002, 4'b0000, 0, 0);
    vt[14] = mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 0, 16'h8002, 4'b0000, 0, 0);
    vt[15] = mk(4'b0100, 16'h0, 16'h0, 16'h0AAA, 16'h0, 4'b0000, 0, 16'h8002, 4'b0000, 0, 0);
    vt[16] = mk(4'b0100, 16'h0, 16'h0, 16'h0AAA, 16'h0, 4'b0100, 0, 16'h8002, 4'b0100, 1, 0);
    vt[17] = mk(4'b0100, 16'h0, 16'h0, 16'h0BBB, 16'h0, 4'b0100, 1, 16'h0AAA, 4'b0100, 1, 0);
    vt[18] = mk(4'b0100, 16'h0, 16'h0, 16'h8CCC, 16'h0, 4'b0100, 1, 16'h0BBB, 4'b0100, 1, 1);
    vt[19] = mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 1, 16'h8CCC, 4'b0000, 0, 0);

    use_gaps      = 1'b0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_flit  = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_flit", bus.out_flit, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_req_ready", bus.req_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cycle table: single packet, SINGLE handoff, orphan BODY, nested HEAD
    for (int r = 0; r < NVEC; r++) begin
      bus.req_valid = vt[r].rv;
      bus.req_flit  = vt[r].fl;
      bus.out_ready = 1'b1;
      #2;
      check($sformatf("v%0d_req_ready", r), bus.req_ready, vt[r].e_rdy);
      check($sformatf("v%0d_out_valid", r), bus.out_valid, vt[r].e_ov);
      check($sformatf("v%0d_out_flit", r), bus.out_flit, vt[r].e_flit);
      check($sformatf("v%0d_grant", r), bus.grant, vt[r].e_gnt);
      check($sformatf("v%0d_busy", r), bus.busy, vt[r].e_busy);
      check($sformatf("v%0d_err", r), bus.err, vt[r].e_err);
      tick();
    end

    // Contention from a fresh pointer: strict order 0,1,2,3
    do_reset();
    for (int i = 0; i < NREQ; i++) gen_packet(i, 3);
    run_drain(100, 100);

    // Backpressure: 5 stalled cycles mid-packet
    do_reset();
    gen_packet(2, 6);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) drive_cycle(!(c >= 4 && c < 9));
    check("bp_drained", exp_q.size(), 0);

    // Reset mid-packet drops the lock and the output register at once
    do_reset();
    gen_packet(1, 5);
    for (int c = 0; c < 4; c++) drive_cycle(1'b1);
    check("mid_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_flit", bus.out_flit, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);

    // Owner goes silent after its HEAD while requester 1 waits
    do_reset();
    bus.req_valid = 4'b0011;
    bus.req_flit  = {16'h0, 16'h0, 16'h0222, 16'h0111};
    bus.out_ready = 1'b1;
    tick();
    check("silent_grant", bus.grant, 4'b0001);
    tick();
    bus.req_valid = 4'b0010;
`ifdef ARB_TIMEOUT_EN
    k = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.err === 1'b1) begin
        k = c;
        break;
      end
      tick();
    end
    check("timeout_latency", k, 15);
    check("timeout_busy", bus.busy, 0);
    check("timeout_grant", bus.grant, 0);
    tick();
    check("timeout_next_grant", bus.grant, 4'b0010);
    check("timeout_err_pulse", bus.err, 0);
`else
    k = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      k++;
    end
    check("hold_cycles", k, 40);
    check("hold_busy", bus.busy, 1);
    check("hold_grant", bus.grant, 4'b0001);
    check("hold_req_ready", bus.req_ready, 4'b0001);
    check("hold_err", bus.err, 0);
`endif

    // Randomized: every requester always has a packet pending, so service is cyclic
    do_reset();
    use_gaps = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NREQ; i++) gen_packet(i, $urandom_range(1, 5));
    end
    run_drain(3000, 70);
    use_gaps = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
Wormhole round-robin arbiter that shares one 16-bit router output link among NREQ flit sources, such as core packetizers or router input FIFOs.
It grants the link on a HEAD flit and holds the grant until that packet's TAIL flit passes, so packets never interleave.
The output is a single registered flit stage with a valid/ready handshake toward the downstream FIFO or link.

Parameters:
NREQ, 4, number of requesters (2..8)
FLIT_W, 16, flit width; bits [15:14] are the type, bits [13:0] the payload
TIMEOUT, 15, idle-cycle limit while locked; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  requester i presents a flit
req_flit  in  NREQ*FLIT_W  flit of requester i in slice [i*FLIT_W +: FLIT_W]
req_ready  out  NREQ  requester i's flit is accepted this cycle
out_valid  out  1  out_flit holds a valid flit
out_flit  out  FLIT_W  registered output flit
out_ready  in  1  downstream accepts out_flit
grant  out  NREQ  one-hot current owner; all zeros in IDLE
busy  out  1  state is LOCKED
err  out  1  one-cycle pulse on protocol error or timeout

Behaviour:
- Flit types (bits [15:14]):
  - 00 = HEAD: src [13:10], des [9:6], data [5:0]
  - 01 = BODY
  - 10 = TAIL
  - 11 = SINGLE, a head that is also the tail
- Reset: state IDLE, rr_ptr=0, grant=0, out_valid=0, out_flit=0, err=0, busy=0, req_ready=0.
- Output stage:
  - space = !out_valid || out_ready.
  - A transfer downstream occurs when out_valid && out_ready.
  - An input flit accepted in cycle t appears on out_flit in cycle t+1.
  - With out_ready held at 1, throughput is one flit per cycle.
- IDLE:
  - Eligible requester: req_valid[i]=1 and flit type is 00 or 11.
  - Winner = first eligible index searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - On a winner: next state LOCKED and grant = onehot(winner). No flit is accepted in the arbitration cycle, so req_ready=0 in IDLE.
  - A non-head flit (01 or 10) presented in IDLE is ignored and not accepted. err pulses for one cycle on the first such cycle of each occurrence.
- LOCKED (owner g):
  - req_ready[g] = space; every other req_ready is 0.
  - An accept (req_valid[g] && req_ready[g]) loads out_flit and sets out_valid.
  - Accepting a TAIL, or a SINGLE as the first flit: next state IDLE, rr_ptr=(g+1) mod NREQ, grant=0.
  - Accepting a HEAD or SINGLE after the first flit is a protocol error: the flit is still forwarded, err pulses, the lock continues.
  - Head-to-grant latency: head valid in cycle t, accepted in t+1, out_valid in t+2.
  - Tail accepted in cycle t → IDLE in t+1 → next packet accepted no earlier than t+2.
- out_valid clears after a downstream transfer unless a new flit is accepted in the same cycle.
- Simultaneous events:
  - Downstream transfer and new accept in the same cycle: out_flit is replaced, out_valid stays 1.
  - Backpressure (out_ready=0 with out_valid=1): req_ready=0, and out_flit must hold stable.
- Reset mid-packet: the lock and output flit are dropped immediately; no partial-packet recovery.
- Fairness: a requester with continuous HEADs waits at most NREQ-1 packets.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A 4-bit idle counter runs in LOCKED. It counts cycles with req_valid[g]=0 and clears on any accept.
  - On reaching TIMEOUT: err pulses, state goes to IDLE, rr_ptr=(g+1) mod NREQ, grant=0.
  - The already-registered output flit is still delivered.
- Undefined: no counter exists, and the lock is held indefinitely.

Decomposition:
- Package noc_pkg holds:
  - FLIT_W=16
  - flit-type constants FLIT_HEAD=2'b00, FLIT_BODY=2'b01, FLIT_TAIL=2'b10, FLIT_SINGLE=2'b11
  - field LSB/MSB constants for type, src, des and data
  - state encoding ARB_IDLE/ARB_LOCKED
- Sub-module rr_picker: combinational round-robin picker; inputs req[NREQ] and ptr; outputs a one-hot winner and a found flag.

Test Plan:
- Single packet: requester 2 sends HEAD 0x0A45, BODY 0x5123, TAIL 0x8FFF with out_ready=1 → outputs appear on cycles 2,3,4 after the HEAD is first valid; grant=4'b0100; busy falls after the tail; rr_ptr=3.
- Contention: all four requesters present 3-flit packets at once, starting with rr_ptr=0 → service order 0,1,2,3; no interleaving of types within any packet.
- Backpressure: out_ready=0 for 5 cycles mid-packet → out_flit stable, req_ready[g]=0; no flit is lost or duplicated after out_ready returns to 1.
- SINGLE flit 0xC123 from requester 1 followed by a HEAD from requester 0 → lock releases after one flit; requester 0 is granted next.
- Orphan BODY 0x4001 from requester 3 in IDLE → err pulses once, req_ready[3]=0, state stays IDLE.
- ARB_TIMEOUT_EN with TIMEOUT=15: owner stops after its HEAD → err pulses 15 cycles later, busy=0, and the next requester is granted.
